// File: rtl/conv2d_lanes.sv
// conv2d_lanes: multi-lane strided 2-D convolution with zero "same" padding.
// Computes LANES output channels per pass, one kernel tap per cycle, with
// optional fused ReLU, round-half-up before rescale, and a saturation counter.
//
// Ports
//   clk, reset        rising-edge clock, synchronous active-high reset
//   start             run request, sampled only in IDLE
//   relu_en, round_en per-run modes, latched when start is accepted
//   input_feature     [IC][IMG][IMG] words, element 0 at the LSBs
//   weights           [OC][IC][K][K] words, element 0 at the LSBs
//   biases            [OC] words, element 0 at the LSBs
//   out_feature       [OC][OUT][OUT] words, element 0 at the LSBs
//   busy, done        run in progress / one-cycle completion pulse
//   sat_count         clipped lane-writes in the current/last run (sticky max)
module conv2d_lanes #(
    parameter int unsigned DATA_WIDTH   = 16,
    parameter int unsigned FRAC_BITS    = 7,
    parameter int unsigned IN_CHANNELS  = 1,
    parameter int unsigned OUT_CHANNELS = 8,
    parameter int unsigned KERNEL       = 3,
    parameter int unsigned IMG_SIZE     = 28,
    parameter int unsigned STRIDE       = 1,
    parameter int unsigned LANES        = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic relu_en,
    input  logic round_en,
    input  logic [IN_CHANNELS*IMG_SIZE*IMG_SIZE*DATA_WIDTH-1:0]         input_feature,
    input  logic [OUT_CHANNELS*IN_CHANNELS*KERNEL*KERNEL*DATA_WIDTH-1:0] weights,
    input  logic [OUT_CHANNELS*DATA_WIDTH-1:0]                           biases,
    output logic [OUT_CHANNELS*((IMG_SIZE-1)/STRIDE+1)*((IMG_SIZE-1)/STRIDE+1)*DATA_WIDTH-1:0] out_feature,
    output logic busy,
    output logic done,
    output logic [31:0] sat_count
);

    localparam int unsigned DW       = DATA_WIDTH;
    localparam int unsigned IC       = IN_CHANNELS;
    localparam int unsigned OC       = OUT_CHANNELS;
    localparam int unsigned K        = KERNEL;
    localparam int unsigned OUT_SIZE = (IMG_SIZE - 1) / STRIDE + 1;
    localparam int unsigned P        = OUT_SIZE * OUT_SIZE;
    localparam int unsigned T        = IC * K * K;
    localparam int unsigned G        = OC / LANES;
    localparam int unsigned PAD      = (K - 1) / 2;
    localparam int unsigned PW       = 2 * DW;
    localparam int unsigned ACCW     = 2 * DW + $clog2(T) + 2;
    localparam int unsigned CW       = $clog2(K + IC + OUT_SIZE + G + 1) + 1;
    localparam int unsigned IN_AW    = $clog2(IC * IMG_SIZE * IMG_SIZE * DW);
    localparam int unsigned W_AW     = $clog2(OC * T * DW);
    localparam int unsigned B_AW     = $clog2(OC * DW);
    localparam int unsigned BK_BITS  = G * P * DW;
    localparam int unsigned BK_AW    = $clog2(BK_BITS);

    localparam logic signed [ACCW-1:0] SAT_MAX = {{(ACCW-DW+1){1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [ACCW-1:0] SAT_MIN = {{(ACCW-DW+1){1'b1}}, {(DW-1){1'b0}}};
    localparam logic signed [ACCW-1:0] RND     = ACCW'(1) <<< (FRAC_BITS - 1);

    // Elaboration-time parameter checks
    if (FRAC_BITS < 1) begin : g_chk_frac
        $error("conv2d_lanes: FRAC_BITS must be >= 1");
    end
    if (LANES < 1 || (OUT_CHANNELS % LANES) != 0) begin : g_chk_lanes
        $error("conv2d_lanes: OUT_CHANNELS must be a multiple of LANES");
    end
    if ((KERNEL % 2) != 1) begin : g_chk_kernel
        $error("conv2d_lanes: KERNEL must be odd");
    end
    if (STRIDE < 1) begin : g_chk_stride
        $error("conv2d_lanes: STRIDE must be >= 1");
    end

    typedef enum logic [1:0] {S_IDLE, S_MAC, S_WRITE, S_FINISH} state_t;

    state_t          state_q;
    logic            busy_q, done_q, relu_q, round_q;
    logic [31:0]     sat_q;
    logic [CW-1:0]   kc_q, kr_q, ic_q, ocol_q, orow_q, g_q;

    logic            tap_last_c, px_last_c, run_last_c;
    logic            preload_c, mac_c, wr_c;
    logic [CW-1:0]   g_sel_c;
    logic signed [DW-1:0] x_c;
    logic [LANES-1:0] clip_c;
    logic [31:0]     sat_d_c;
    logic [32:0]     sat_sum_c;
    int              ir_c, icol_c, x_idx_c, wr_idx_c;
    logic            in_ok_c;

    assign busy      = busy_q;
    assign done      = done_q;
    assign sat_count = sat_q;

    // Shared control decode, input tap fetch and saturation-count update
    always_comb begin
        tap_last_c = (kc_q == CW'(K - 1)) && (kr_q == CW'(K - 1)) && (ic_q == CW'(IC - 1));
        px_last_c  = (ocol_q == CW'(OUT_SIZE - 1)) && (orow_q == CW'(OUT_SIZE - 1));
        run_last_c = px_last_c && (g_q == CW'(G - 1));
        preload_c  = ((state_q == S_IDLE) && start) || (state_q == S_WRITE);
        mac_c      = (state_q == S_MAC);
        wr_c       = (state_q == S_WRITE);

        // Bias group for the next pixel: same group, next group, or group 0 at run start
        g_sel_c = '0;
        if (state_q == S_WRITE && !run_last_c) begin
            g_sel_c = px_last_c ? g_q + CW'(1) : g_q;
        end

        ir_c    = int'(orow_q) * int'(STRIDE) + int'(kr_q) - int'(PAD);
        icol_c  = int'(ocol_q) * int'(STRIDE) + int'(kc_q) - int'(PAD);
        in_ok_c = (ir_c >= 0) && (ir_c < int'(IMG_SIZE)) &&
                  (icol_c >= 0) && (icol_c < int'(IMG_SIZE));
        x_idx_c = in_ok_c ? ((int'(ic_q) * int'(IMG_SIZE) + ir_c) * int'(IMG_SIZE) + icol_c) : 0;
        x_c     = in_ok_c ? input_feature[IN_AW'(x_idx_c * int'(DW)) +: DW] : '0;

        wr_idx_c = int'(g_q) * int'(P) + int'(orow_q) * int'(OUT_SIZE) + int'(ocol_q);

        sat_sum_c = {1'b0, sat_q} + 33'($countones(clip_c));
        sat_d_c   = sat_sum_c[32] ? '1 : sat_sum_c[31:0];
    end

    // Per-lane datapath: accumulator, rescale/saturate/ReLU, and its output bank
    for (genvar l = 0; l < int'(LANES); l++) begin : g_lane
        logic signed [DW-1:0]   w_c, b_c, wval_c;
        logic signed [PW-1:0]   prod_c;
        logic signed [ACCW-1:0] acc_q, sum_c, shf_c;
        logic                   clip_hi_c, clip_lo_c;
        logic [BK_BITS-1:0]     bank_q;
        int                     w_idx_c;

        always_comb begin
            w_idx_c = (((int'(g_q) * int'(LANES) + l) * int'(IC) + int'(ic_q)) * int'(K)
                       + int'(kr_q)) * int'(K) + int'(kc_q);
            w_c     = weights[W_AW'(w_idx_c * int'(DW)) +: DW];
            b_c     = biases[B_AW'((int'(g_sel_c) * int'(LANES) + l) * int'(DW)) +: DW];
            prod_c  = PW'(x_c) * PW'(w_c);

            sum_c     = acc_q + (round_q ? RND : '0);
            shf_c     = sum_c >>> FRAC_BITS;
            clip_hi_c = (shf_c > SAT_MAX);
            clip_lo_c = (shf_c < SAT_MIN);
            wval_c    = clip_hi_c ? DW'(SAT_MAX) : (clip_lo_c ? DW'(SAT_MIN) : DW'(shf_c));
            // ReLU after saturation: a negative clip still counts but stores 0
            if (relu_q && wval_c[DW-1]) begin
                wval_c = '0;
            end
        end

        assign clip_c[l] = wr_c && (clip_hi_c || clip_lo_c);

        always_ff @(posedge clk) begin
            if (reset) begin
                acc_q  <= '0;
                bank_q <= '0;
            end else begin
                if (preload_c) begin
                    acc_q <= ACCW'(b_c) <<< FRAC_BITS;
                end else if (mac_c) begin
                    acc_q <= acc_q + ACCW'(prod_c);
                end
                if (wr_c) begin
                    bank_q[BK_AW'(wr_idx_c * int'(DW)) +: DW] <= wval_c;
                end
            end
        end

        // Bank word (g, p) holds output channel g*LANES+l, pixel p
        for (genvar gg = 0; gg < int'(G); gg++) begin : g_grp
            for (genvar pp = 0; pp < int'(P); pp++) begin : g_px
                assign out_feature[((gg * LANES + l) * P + pp) * DW +: DW] =
                    bank_q[(gg * P + pp) * DW +: DW];
            end
        end
    end

    // Control FSM: IDLE -> MAC -> WRITE -> (MAC | FINISH) -> IDLE
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            relu_q  <= 1'b0;
            round_q <= 1'b0;
            sat_q   <= '0;
            kc_q    <= '0;
            kr_q    <= '0;
            ic_q    <= '0;
            ocol_q  <= '0;
            orow_q  <= '0;
            g_q     <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        relu_q  <= relu_en;
                        round_q <= round_en;
                        sat_q   <= '0;
                        kc_q    <= '0;
                        kr_q    <= '0;
                        ic_q    <= '0;
                        ocol_q  <= '0;
                        orow_q  <= '0;
                        g_q     <= '0;
                        busy_q  <= 1'b1;
                        state_q <= S_MAC;
                    end
                end
                S_MAC: begin
                    if (kc_q == CW'(K - 1)) begin
                        kc_q <= '0;
                        if (kr_q == CW'(K - 1)) begin
                            kr_q <= '0;
                            ic_q <= (ic_q == CW'(IC - 1)) ? '0 : ic_q + CW'(1);
                        end else begin
                            kr_q <= kr_q + CW'(1);
                        end
                    end else begin
                        kc_q <= kc_q + CW'(1);
                    end
                    if (tap_last_c) begin
                        state_q <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    sat_q   <= sat_d_c;
                    state_q <= run_last_c ? S_FINISH : S_MAC;
                    if (ocol_q == CW'(OUT_SIZE - 1)) begin
                        ocol_q <= '0;
                        if (orow_q == CW'(OUT_SIZE - 1)) begin
                            orow_q <= '0;
                            g_q    <= (g_q == CW'(G - 1)) ? '0 : g_q + CW'(1);
                        end else begin
                            orow_q <= orow_q + CW'(1);
                        end
                    end else begin
                        ocol_q <= ocol_q + CW'(1);
                    end
                end
                S_FINISH: begin
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_conv2d_lanes.sv
// Scoreboard bench for conv2d_lanes: two instances (IMG4/S1 and IMG5/S2),
// expected runs queued at issue time, monitors compare on each done pulse.
module tb_conv2d_lanes;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A: IC1 OC2 K3 IMG4 S1 L2 (OUT 4, P 16)
    logic              rst_a, start_a, relu_a, round_a, busy_a, done_a;
    logic [15:0][15:0] in_a;
    logic [17:0][15:0] w_a;
    logic [1:0][15:0]  b_a;
    logic [31:0][15:0] out_a;
    logic [31:0]       sat_a;

    // Instance B: IC1 OC2 K3 IMG5 S2 L2 (OUT 3, P 9)
    logic              rst_b, start_b, relu_b, round_b, busy_b, done_b;
    logic [24:0][15:0] in_b;
    logic [17:0][15:0] w_b;
    logic [1:0][15:0]  b_b;
    logic [17:0][15:0] out_b;
    logic [31:0]       sat_b;

    conv2d_lanes #(.DATA_WIDTH(16), .FRAC_BITS(7), .IN_CHANNELS(1), .OUT_CHANNELS(2),
                   .KERNEL(3), .IMG_SIZE(4), .STRIDE(1), .LANES(2)) dut_a (
        .clk(clk), .reset(rst_a), .start(start_a), .relu_en(relu_a), .round_en(round_a),
        .input_feature(in_a), .weights(w_a), .biases(b_a), .out_feature(out_a),
        .busy(busy_a), .done(done_a), .sat_count(sat_a));

    conv2d_lanes #(.DATA_WIDTH(16), .FRAC_BITS(7), .IN_CHANNELS(1), .OUT_CHANNELS(2),
                   .KERNEL(3), .IMG_SIZE(5), .STRIDE(2), .LANES(2)) dut_b (
        .clk(clk), .reset(rst_b), .start(start_b), .relu_en(relu_b), .round_en(round_b),
        .input_feature(in_b), .weights(w_b), .biases(b_b), .out_feature(out_b),
        .busy(busy_b), .done(done_b), .sat_count(sat_b));

    typedef struct packed {
        logic [31:0] lat;
        logic [31:0] sat;
        logic [31:0] n;
    } hdr_t;

    hdr_t        hq_a[$], hq_b[$];
    logic [15:0] wq_a[$], wq_b[$];
    hdr_t        ha, hb;
    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    int          st_a = 0;
    int          st_b = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic push_hdr_a(input int lat, input int sat, input int n);
        hdr_t h;
        h.lat = 32'(lat); h.sat = 32'(sat); h.n = 32'(n);
        hq_a.push_back(h);
    endtask

    task automatic push_hdr_b(input int lat, input int sat, input int n);
        hdr_t h;
        h.lat = 32'(lat); h.sat = 32'(sat); h.n = 32'(n);
        hq_b.push_back(h);
    endtask

    // Two-channel uniform expectation for instance A
    task automatic push_uni_a(input int sat, input logic [15:0] v0, input logic [15:0] v1);
        push_hdr_a(162, sat, 32);
        for (int i = 0; i < 16; i++) wq_a.push_back(v0);
        for (int i = 0; i < 16; i++) wq_a.push_back(v1);
    endtask

    // Monitor A: on done, pop a run and compare latency, sat_count and every word
    always @(negedge clk) begin
        if (done_a === 1'b1) begin
            if (hq_a.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL a_unexpected_done: got done=1 expected no pending run");
            end else begin
                ha = hq_a.pop_front();
                check("a_latency", 32'(cyc - st_a + 1), ha.lat);
                check("a_sat_count", sat_a, ha.sat);
                check("a_busy_at_done", 32'(busy_a), 32'd0);
                for (int i = 0; i < int'(ha.n); i++) begin
                    logic [15:0] e;
                    e = wq_a.pop_front();
                    check($sformatf("a_out[%0d]", i), 32'(out_a[5'(i)]), 32'(e));
                end
            end
        end
    end

    // Monitor B
    always @(negedge clk) begin
        if (done_b === 1'b1) begin
            if (hq_b.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL b_unexpected_done: got done=1 expected no pending run");
            end else begin
                hb = hq_b.pop_front();
                check("b_latency", 32'(cyc - st_b + 1), hb.lat);
                check("b_sat_count", sat_b, hb.sat);
                check("b_busy_at_done", 32'(busy_b), 32'd0);
                for (int i = 0; i < int'(hb.n); i++) begin
                    logic [15:0] e;
                    e = wq_b.pop_front();
                    check($sformatf("b_out[%0d]", i), 32'(out_b[5'(i)]), 32'(e));
                end
            end
        end
    end

    // Mode inputs are flipped after the start cycle to exercise latching
    task automatic go_a(input logic relu, input logic rnd);
        @(negedge clk);
        relu_a = relu; round_a = rnd; start_a = 1'b1; st_a = cyc + 1;
        @(negedge clk);
        start_a = 1'b0; relu_a = ~relu; round_a = ~rnd;
        check("a_busy_after_start", 32'(busy_a), 32'd1);
    endtask

    task automatic go_b(input logic relu, input logic rnd);
        @(negedge clk);
        relu_b = relu; round_b = rnd; start_b = 1'b1; st_b = cyc + 1;
        @(negedge clk);
        start_b = 1'b0; relu_b = ~relu; round_b = ~rnd;
        check("b_busy_after_start", 32'(busy_b), 32'd1);
    endtask

    task automatic wait_a();
        int n = 0;
        while ((hq_a.size() != 0 || busy_a) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2000) begin
            checks++;
            errors++;
            $display("FAIL a_timeout: got no done after %0d cycles expected done", n);
            hq_a.delete();
            wq_a.delete();
        end
    endtask

    task automatic wait_b();
        int n = 0;
        while ((hq_b.size() != 0 || busy_b) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2000) begin
            checks++;
            errors++;
            $display("FAIL b_timeout: got no done after %0d cycles expected done", n);
            hq_b.delete();
            wq_b.delete();
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got simulation still running expected finish");
        $fatal(1, "watchdog expired");
    end

    int ramp[16] = '{3, -7, 12, 0, 25, -1, 8, 100, -128, 64, 5, -33, 77, 2, -90, 9};
    int t2[9]    = '{512, 768, 512, 768, 1152, 768, 512, 768, 512};
    int t2h[9]   = '{256, 384, 256, 384, 576, 384, 256, 384, 256};

    initial begin
        rst_a = 1'b1; start_a = 1'b0; relu_a = 1'b0; round_a = 1'b0;
        rst_b = 1'b1; start_b = 1'b0; relu_b = 1'b0; round_b = 1'b0;
        in_a = '0; w_a = '0; b_a = '0;
        in_b = '0; w_b = '0; b_b = '0;
        repeat (3) @(negedge clk);
        rst_a = 1'b0;
        rst_b = 1'b0;

        // Reset state
        check("a_reset_busy", 32'(busy_a), 32'd0);
        check("a_reset_done", 32'(done_a), 32'd0);
        check("a_reset_sat", sat_a, 32'd0);
        check("b_reset_busy", 32'(busy_b), 32'd0);
        check("a_reset_out_zero", 32'(out_a != '0), 32'd0);
        check("b_reset_out_zero", 32'(out_b != '0), 32'd0);

        // Identity kernel (centre tap 1.0) reproduces the input on both channels
        for (int j = 0; j < 16; j++) in_a[4'(j)] = 16'(ramp[j]);
        w_a = '0;
        w_a[5'(4)]  = 16'd128;
        w_a[5'(13)] = 16'd128;
        b_a = '0;
        push_hdr_a(162, 0, 32);
        for (int c = 0; c < 2; c++)
            for (int j = 0; j < 16; j++) wq_a.push_back(16'(ramp[j]));
        go_a(1'b0, 1'b0);
        wait_a();

        // Same run with a start pulse mid-run: ignored, latency unchanged
        push_hdr_a(162, 0, 32);
        for (int c = 0; c < 2; c++)
            for (int j = 0; j < 16; j++) wq_a.push_back(16'(ramp[j]));
        go_a(1'b0, 1'b0);
        repeat (50) @(negedge clk);
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        wait_a();

        // Stride 2 on a 5x5 all-1.0 image: padding shapes the border sums
        in_b = {25{16'd128}};
        w_b  = {{9{16'd64}}, {9{16'd128}}};
        b_b  = '0;
        push_hdr_b(92, 0, 18);
        for (int j = 0; j < 9; j++) wq_b.push_back(16'(t2[j]));
        for (int j = 0; j < 9; j++) wq_b.push_back(16'(t2h[j]));
        go_b(1'b0, 1'b0);
        wait_b();

        // Positive saturation on every write, then negative clips masked by ReLU
        in_a = {16{16'h7FFF}};
        w_a  = {18{16'h7FFF}};
        push_uni_a(32, 16'h7FFF, 16'h7FFF);
        go_a(1'b0, 1'b0);
        wait_a();
        w_a = {18{16'h8001}};
        push_uni_a(32, 16'h0000, 16'h0000);
        go_a(1'b1, 1'b0);
        wait_a();

        // Half-LSB results: floor vs round-half-up, both signs
        in_a = {16{16'h0001}};
        w_a  = '0;
        w_a[5'(4)]  = 16'd64;
        w_a[5'(13)] = 16'hFFC0;
        push_uni_a(0, 16'h0000, 16'hFFFF);
        go_a(1'b0, 1'b0);
        wait_a();
        push_uni_a(0, 16'h0001, 16'h0000);
        go_a(1'b0, 1'b1);
        wait_a();

        // Reset mid-MAC aborts: no done, busy low, outputs and count cleared
        go_a(1'b0, 1'b0);
        repeat (30) @(negedge clk);
        rst_a = 1'b1;
        @(negedge clk);
        rst_a = 1'b0;
        check("a_abort_busy", 32'(busy_a), 32'd0);
        check("a_abort_done", 32'(done_a), 32'd0);
        check("a_abort_sat", sat_a, 32'd0);
        for (int i = 0; i < 32; i++)
            check($sformatf("a_abort_out[%0d]", i), 32'(out_a[5'(i)]), 32'd0);
        repeat (200) @(negedge clk);
        check("a_abort_idle", 32'(busy_a), 32'd0);

        // Bias only: negative bias passes without ReLU, is zeroed with it
        in_a = '0;
        b_a[1'(0)] = 16'hFF80;
        b_a[1'(1)] = 16'h0005;
        push_uni_a(0, 16'hFF80, 16'h0005);
        go_a(1'b0, 1'b0);
        wait_a();
        push_uni_a(0, 16'h0000, 16'h0005);
        go_a(1'b1, 1'b0);
        wait_a();

        repeat (5) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
